// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Latency 33 cycles from acceptance to result; start and MTHI/MTLO are ignored while busy.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state, state_nxt;
    logic [1:0]  op_r;
    logic        s1, s2;
    logic [31:0] a_r, b_r;
    logic [4:0]  cnt;
    logic [63:0] acc;

    logic        is_div;
    logic        in_s1, in_s2;
    logic [31:0] in_a, in_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_nxt;
    logic [32:0] rem_sh, diff;
    logic        ge;
    logic [63:0] div_nxt;
    logic [63:0] prod;
    logic [31:0] res_hi, res_lo;

    assign is_div = op_r[1];
    assign busy   = (state != IDLE);

    // op[0]==0 selects the signed variants; unsigned ops latch zero signs so no correction fires
    assign in_s1 = ~op[0] & op1[31];
    assign in_s2 = ~op[0] & op2[31];
    assign in_a  = in_s1 ? -op1 : op1;
    assign in_b  = in_s2 ? -op2 : op2;

    // Multiplier bits and dividend bits are indexed by the counter so the operands stay intact
    assign mul_sum = {1'b0, acc[63:32]} + (b_r[cnt] ? {1'b0, a_r} : 33'd0);
    assign mul_nxt = {mul_sum, acc[31:1]};

    assign rem_sh  = {acc[63:32], a_r[5'd31 - cnt]};
    assign ge      = (rem_sh >= {1'b0, b_r});
    assign diff    = rem_sh - {1'b0, b_r};
    assign div_nxt = {(ge ? diff[31:0] : rem_sh[31:0]), acc[30:0], ge};

    always_comb begin
        prod   = acc;
        res_hi = acc[63:32];
        res_lo = acc[31:0];
        if (!is_div) begin
            if (s1 ^ s2)
                prod = -acc;
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else if (b_r == 32'd0) begin
            res_lo = 32'hFFFF_FFFF;
            res_hi = s1 ? -a_r : a_r;
        end else begin
            if (s1 ^ s2)
                res_lo = -acc[31:0];
            if (s1)
                res_hi = -acc[63:32];
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == 5'd31) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= 2'b00;
            s1   <= 1'b0;
            s2   <= 1'b0;
            a_r  <= 32'd0;
            b_r  <= 32'd0;
            cnt  <= 5'd0;
            acc  <= 64'd0;
            done <= 1'b0;
            hi   <= 32'd0;
            lo   <= 32'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_r <= op;
                        s1   <= in_s1;
                        s2   <= in_s2;
                        a_r  <= in_a;
                        b_r  <= in_b;
                        cnt  <= 5'd0;
                        acc  <= 64'd0;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                RUN: begin
                    acc <= is_div ? div_nxt : mul_nxt;
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply/divide unit with architectural HI/LO registers. It sequences a 32-iteration shift-add multiplier and restoring divider for MULT, MULTU, DIV and DIVU. It replaces the single-cycle combinational product/quotient path with a registered, stall-capable resource. It sits beside the ALU in the execute stage: the decoder issues mult/div operations, MFHI/MFLO read `hi`/`lo`, and MTHI/MTLO write them.

## Interface
- Parameters: none. The width is fixed at 32.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: issue request; accepted only when `busy`=0.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `op1` in 32: rs operand (multiplicand / dividend).
- `op2` in 32: rt operand (multiplier / divisor).
- `mthi` in 1: write `wdata` to HI.
- `mtlo` in 1: write `wdata` to LO.
- `wdata` in 32: MTHI/MTLO data.
- `busy` out 1: operation in progress; the pipeline stalls MFHI/MFLO and new mult/div while high.
- `done` out 1: one-cycle pulse when HI/LO take a new result.
- `hi` out 32: HI register (remainder / upper product).
- `lo` out 32: LO register (quotient / lower product).

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE → RUN on `start`. The edge latches `op`, `|op1|`, `|op2|` (magnitudes for signed ops, raw values for unsigned ops) and the operand signs, and clears the 5-bit iteration counter and the 64-bit accumulator.
- RUN performs one iteration per cycle for 32 cycles, counter 0..31, then → FIX.
  - Multiply: if the current multiplier LSB is 1, add the multiplicand into the upper accumulator half; then shift right 1. Carry-out is kept (33-bit add).
  - Divide (restoring): shift {rem,quot} left 1; trial-subtract the divisor from rem (33-bit); if non-negative, keep the difference and set quot LSB=1.
- FIX lasts one cycle and applies sign correction, then writes HI/LO and returns to IDLE.
  - MULT: if the signs differ, negate the 64-bit product. HI=product[63:32], LO=product[31:0].
  - DIV: LO=quotient, negated if the signs differ. HI=remainder, negated if the dividend is negative (truncating division).
  - Unsigned ops: no correction.
- Divide by zero (DIV or DIVU) is defined, not unpredictable: LO=0xFFFFFFFF, HI=op1 as originally latched. No sign correction is applied.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. There is no trap.
- `start` while `busy`=1 is ignored; there is no queue.
- `mthi`/`mtlo` while `busy`=1 are ignored.
- In IDLE, `mthi`/`mtlo` write on the edge.
- `start` takes priority over `mthi`/`mtlo` in the same cycle; the writes are dropped.
- `mthi` and `mtlo` together write both registers.
- Operand inputs are don't-care after the acceptance edge.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0. Any in-flight operation is abandoned and no partial result is written.
- Acceptance at edge E0: `busy`=1 from E0 through E33 (33 cycles: 32 RUN + 1 FIX).
- At edge E33: `hi`/`lo` take the result, `busy`=0, `done`=1.
- At E34: `done`=0.
- Back-to-back operation: `start` may be high in the cycle after E33; it is accepted at E34.
- MTHI/MTLO latency: 1 edge; visible on `hi`/`lo` in the next cycle.
- `hi`/`lo` hold the previous values throughout RUN/FIX and never show intermediate accumulator state.
- All outputs are registered; no combinational input-to-output path.

## Test plan
- MULT op1=0xFFFFFFFD (−3), op2=7 → after 33 busy cycles: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `done` pulses once.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU 0x00001234 / 0 → `lo`=0xFFFFFFFF, `hi`=0x00001234.
- Stress `start`, `mthi` and reset:
  - `start` (MULTU 2×3) held high for the full operation, plus `mthi` with `wdata`=0xDEAD during `busy` → exactly one result (`lo`=6, `hi`=0); 0xDEAD is never written.
  - `mtlo` with `wdata`=0x55 in IDLE → `lo`=0x55 the next cycle.
- `rst_n` low at RUN cycle 10 → `busy`, `done`, `hi` and `lo` are all 0 immediately. After release, a DIVU 100/7 completes normally with `lo`=14, `hi`=2.
